// File: rtl/traffic_light_xing.sv
// Two-road crossing controller with a pedestrian-request button.
// Optional night flash mode is compiled in with the macro NIGHT_MODE_EN,
// which adds the night input and the FLASH state.
module traffic_light_xing #(
    parameter int TICK_DIV   = 4,
    parameter int T_MAIN_GRN = 20,
    parameter int T_MAIN_MIN = 5,
    parameter int T_SIDE_GRN = 10,
    parameter int T_YEL      = 3,
    parameter int T_ALLRED   = 1,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       res,
    input  logic       btn,
`ifdef NIGHT_MODE_EN
    input  logic       night,
`endif
    output logic [2:0] main_led,
    output logic [2:0] side_led,
    output logic       walk
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_MAIN_GRN = 3'd0,
        S_MAIN_YEL = 3'd1,
        S_ALLRED1  = 3'd2,
        S_SIDE_GRN = 3'd3,
        S_SIDE_YEL = 3'd4,
        S_ALLRED2  = 3'd5
`ifdef NIGHT_MODE_EN
        , S_FLASH  = 3'd6
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic              req_q, req_d;
    logic              sync1_q, sync2_q;
    logic              tick;
    logic              btn_rise;
`ifdef NIGHT_MODE_EN
    logic              flash_on_q, flash_on_d;
    logic              flash_flip;
`endif

    assign tick     = (presc_q == PS_W'(TICK_DIV - 1));
    // Rising edge of the synchronised button, registered into req on the
    // same edge that the second synchroniser flop goes high.
    assign btn_rise = sync1_q & ~sync2_q;

    // State, timing and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= S_MAIN_GRN;
            presc_q    <= '0;
            phase_q    <= '0;
            req_q      <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
`ifdef NIGHT_MODE_EN
            flash_on_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            phase_q    <= phase_d;
            req_q      <= req_d;
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
`ifdef NIGHT_MODE_EN
            flash_on_q <= flash_on_d;
`endif
        end
    end

    // Next-state, phase counter, prescaler and request logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_MAIN_GRN: if (tick && ((phase_q == CNT_W'(T_MAIN_GRN - 1)) ||
                                     (req_q && (phase_q >= CNT_W'(T_MAIN_MIN - 1)))))
                            state_d = S_MAIN_YEL;
            S_MAIN_YEL: if (tick && (phase_q == CNT_W'(T_YEL - 1)))      state_d = S_ALLRED1;
            S_ALLRED1:  if (tick && (phase_q == CNT_W'(T_ALLRED - 1)))   state_d = S_SIDE_GRN;
            S_SIDE_GRN: if (tick && (phase_q == CNT_W'(T_SIDE_GRN - 1))) state_d = S_SIDE_YEL;
            S_SIDE_YEL: if (tick && (phase_q == CNT_W'(T_YEL - 1)))      state_d = S_ALLRED2;
            S_ALLRED2:  if (tick && (phase_q == CNT_W'(T_ALLRED - 1)))   state_d = S_MAIN_GRN;
`ifdef NIGHT_MODE_EN
            S_FLASH:    state_d = S_ALLRED2;
`endif
            default:    state_d = S_MAIN_GRN;
        endcase
`ifdef NIGHT_MODE_EN
        if (night) state_d = S_FLASH;
        flash_flip = (state_q == S_FLASH) && (state_d == S_FLASH) &&
                     tick && (phase_q == CNT_W'(T_YEL - 1));
        flash_on_d = flash_on_q;
        if ((state_d == S_FLASH) && (state_q != S_FLASH)) flash_on_d = 1'b1;
        else if (flash_flip)                               flash_on_d = ~flash_on_q;
`endif

        // The prescaler restarts on every state change so that a phase
        // entered off-tick (night mode) still lasts exactly T*TICK_DIV cycles;
        // for tick-driven changes it wraps to zero anyway.
        if (state_d != state_q) begin
            presc_d = '0;
            phase_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            phase_d = tick ? phase_q + 1'b1 : phase_q;
`ifdef NIGHT_MODE_EN
            if (flash_flip) phase_d = '0;
`endif
        end

        // Requests made during the walk phase are dropped; clear beats set.
        req_d = req_q;
        if (btn_rise && (state_q != S_SIDE_GRN)) req_d = 1'b1;
        if ((state_d == S_SIDE_GRN) || (state_q == S_SIDE_GRN)) req_d = 1'b0;
`ifdef NIGHT_MODE_EN
        if ((state_d == S_FLASH) || (state_q == S_FLASH)) req_d = 1'b0;
`endif
    end

    // Moore decode of the lamp outputs from the state register.
    always_comb begin
        main_led = 3'b100;
        side_led = 3'b100;
        walk     = 1'b0;
        unique case (state_q)
            S_MAIN_GRN: main_led = 3'b001;
            S_MAIN_YEL: main_led = 3'b010;
            S_SIDE_GRN: begin
                side_led = 3'b001;
                walk     = 1'b1;
            end
            S_SIDE_YEL: side_led = 3'b010;
`ifdef NIGHT_MODE_EN
            S_FLASH: begin
                main_led = flash_on_q ? 3'b010 : 3'b000;
                side_led = flash_on_q ? 3'b010 : 3'b000;
            end
`endif
            default: begin
                main_led = 3'b100;
                side_led = 3'b100;
            end
        endcase
    end

endmodule
